// File: rtl/uart_dbg_fmt.sv
// uart_dbg_fmt: debug UART transmitter with a word FIFO.
// Queued words go out on an 8N1 line, either as uppercase ASCII hex
// (optionally followed by CR LF) or as raw big-endian bytes.
module uart_dbg_fmt #(
  parameter int SYS_CLK_FREQ   = 48_000_000,
  parameter int BAUD_RATE      = 3_000_000,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 16,
  parameter bit HEX_MODE       = 1'b1,
  parameter bit APPEND_NEWLINE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  tx,
  output logic                  full,
  output logic                  empty,
  output logic                  busy,
  output logic [7:0]            dropped
);

  localparam int BIT_CYCLES = SYS_CLK_FREQ / BAUD_RATE;
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam int NUM_CHARS  = HEX_MODE ? (DATA_WIDTH / 4 + (APPEND_NEWLINE ? 2 : 0))
                                       : (DATA_WIDTH / 8);
  localparam int IDX_W      = $clog2(NUM_CHARS) + 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int FCNT_W     = PTR_W + 1;

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  CHAR_LAST = IDX_W'(NUM_CHARS - 1);
  localparam logic [FCNT_W-1:0] DEPTH_C   = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- FIFO
  // Small distributed-RAM FIFO; the head word is read combinationally so
  // the pop edge can capture it straight into the word register.
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]     count_q, count_d;
  logic                  full_q, empty_q;
  logic [7:0]            dropped_q;
  logic                  push, pop;

  assign push = wr && !full_q;

  // Occupancy next-state: a push and a pop on the same edge cancel out.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array write port (no reset needed on the data itself).
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Pointers, count, registered flags and the saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      dropped_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
      empty_q <= (count_d == '0);
      if (wr && full_q && (dropped_q != 8'hFF)) begin
        dropped_q <= dropped_q + 1'b1;
      end
    end
  end

  // ----------------------------------------------------------- formatter
  // Character number i of word w: hex digits MSB nibble first then CR LF,
  // or raw bytes most significant first.
  function automatic logic [7:0] char_at(input logic [DATA_WIDTH-1:0] w,
                                         input logic [IDX_W-1:0]      i);
    logic [DATA_WIDTH-1:0] sh;
    logic [3:0]            nib;
    sh      = '0;
    nib     = '0;
    char_at = 8'h0A;
    if (HEX_MODE) begin
      if (int'(i) < DATA_WIDTH / 4) begin
        sh  = w >> (DATA_WIDTH - 4 * (int'(i) + 1));
        nib = sh[3:0];
        char_at = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
      end else if (int'(i) == DATA_WIDTH / 4) begin
        char_at = 8'h0D;
      end else begin
        char_at = 8'h0A;
      end
    end else begin
      sh      = w >> (DATA_WIDTH - 8 * (int'(i) + 1));
      char_at = sh[7:0];
    end
  endfunction

  // ---------------------------------------------------------- serializer
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            char_q, char_d;
  logic [2:0]            bit_q, bit_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  // Serializer state register; tx is forced high on the reset edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      char_q  <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: bit timing by a down-counter reloaded every bit so
  // boundaries never drift; characters of one word are sent back to back.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    char_d  = char_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!empty_q) begin
          pop     = 1'b1;
          word_d  = mem_q[rd_ptr_q];
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        char_d  = char_at(word_q, idx_q);
        tx_d    = 1'b0;
        cnt_d   = BIT_LAST;
        state_d = S_START;
      end
      S_START: begin
        if (cnt_q == '0) begin
          tx_d    = char_q[0];
          char_d  = char_q >> 1;
          bit_d   = '0;
          cnt_d   = BIT_LAST;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = BIT_LAST;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            tx_d   = char_q[0];
            char_d = char_q >> 1;
            bit_d  = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          if (idx_q != CHAR_LAST) begin
            // Next character of the same word starts with no idle gap.
            idx_d   = idx_q + 1'b1;
            char_d  = char_at(word_q, idx_q + 1'b1);
            tx_d    = 1'b0;
            cnt_d   = BIT_LAST;
            state_d = S_START;
          end else if (!empty_q) begin
            pop     = 1'b1;
            word_d  = mem_q[rd_ptr_q];
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign full    = full_q;
  assign empty   = empty_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_uart_dbg_fmt.sv
// Bench for uart_dbg_fmt: a 16-bit hex/CRLF instance with a 4-word FIFO and
// a 16-bit raw instance with a 16-word FIFO, both at 16 clocks per bit.
module tb_uart_dbg_fmt;
  localparam int BC = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        wr_h = 1'b0;
  logic [15:0] din_h = '0;
  logic        tx_h, full_h, empty_h, busy_h;
  logic [7:0]  drop_h;
  logic        wr_r = 1'b0;
  logic [15:0] din_r = '0;
  logic        tx_r, full_r, empty_r, busy_r;
  logic [7:0]  drop_r;

  uart_dbg_fmt #(.SYS_CLK_FREQ(48_000_000), .BAUD_RATE(3_000_000), .DATA_WIDTH(16),
                 .FIFO_DEPTH(4), .HEX_MODE(1'b1), .APPEND_NEWLINE(1'b1)) u_hex (
    .clk(clk), .reset(reset), .wr(wr_h), .data_in(din_h), .tx(tx_h),
    .full(full_h), .empty(empty_h), .busy(busy_h), .dropped(drop_h));

  uart_dbg_fmt #(.SYS_CLK_FREQ(48_000_000), .BAUD_RATE(3_000_000), .DATA_WIDTH(16),
                 .FIFO_DEPTH(16), .HEX_MODE(1'b0), .APPEND_NEWLINE(1'b0)) u_raw (
    .clk(clk), .reset(reset), .wr(wr_r), .data_in(din_r), .tx(tx_r),
    .full(full_r), .empty(empty_r), .busy(busy_r), .dropped(drop_r));

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  rx_h[$], rx_r[$], exp_h[$], exp_r[$];
  int unsigned ts_h[$], ts_r[$];
  int          ferr_h = 0, ferr_r = 0;

  function automatic logic get_tx(input int ch);   return (ch == 0) ? tx_h   : tx_r;   endfunction
  function automatic logic get_busy(input int ch); return (ch == 0) ? busy_h : busy_r; endfunction

  // Reference model: the characters a word must produce on the line.
  function automatic void model_word(input int ch, input logic [15:0] w);
    int d;
    if (ch == 0) begin
      for (int k = 0; k < 4; k++) begin
        d = int'((w >> (12 - 4 * k)) & 16'hF);
        exp_h.push_back(8'((d < 10) ? (48 + d) : (55 + d)));
      end
      exp_h.push_back(8'h0D);
      exp_h.push_back(8'h0A);
    end else begin
      exp_r.push_back(w[15:8]);
      exp_r.push_back(w[7:0]);
    end
  endfunction

  // Line decoder: samples every clock of a frame, requires each bit to be
  // flat for exactly BC clocks, records byte and start time.
  task automatic mon_run(input int ch);
    logic [7:0]  b;
    logic        v;
    int unsigned st;
    bit          bad, abort;
    forever begin
      @(negedge clk);
      if (!reset && get_tx(ch) === 1'b0) begin
        st = cyc; b = '0; bad = 0; abort = 0;
        for (int s = 1; s < 10 * BC && !abort; s++) begin
          @(negedge clk);
          if (reset) abort = 1;
          else begin
            v = get_tx(ch);
            if (s / BC == 0)      begin if (v !== 1'b0) bad = 1; end
            else if (s / BC == 9) begin if (v !== 1'b1) bad = 1; end
            else if (s % BC == 0) b[s / BC - 1] = v;
            else if (v !== b[s / BC - 1]) bad = 1;
          end
        end
        if (!abort) begin
          if (ch == 0) begin rx_h.push_back(b); ts_h.push_back(st); if (bad) ferr_h++; end
          else         begin rx_r.push_back(b); ts_r.push_back(st); if (bad) ferr_r++; end
        end
      end
    end
  endtask

  initial mon_run(0);
  initial mon_run(1);

  task automatic clear_queues();
    rx_h.delete(); rx_r.delete(); exp_h.delete(); exp_r.delete();
    ts_h.delete(); ts_r.delete(); ferr_h = 0; ferr_r = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_queues();
  endtask

  task automatic wait_idle(input int ch, input int limit, output int busy_cycles, output bit timeout);
    busy_cycles = 0; timeout = 1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (get_busy(ch)) busy_cycles++;
      else begin timeout = 0; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (tx_h !== 1'b1)   begin n_err++; $display("FAIL reset_tx_h: got %b want 1", tx_h); end
    n_cmp++; if (full_h !== 1'b0) begin n_err++; $display("FAIL reset_full_h: got %b want 0", full_h); end
    n_cmp++; if (empty_h !== 1'b1) begin n_err++; $display("FAIL reset_empty_h: got %b want 1", empty_h); end
    n_cmp++; if (busy_h !== 1'b0) begin n_err++; $display("FAIL reset_busy_h: got %b want 0", busy_h); end
    n_cmp++; if (drop_h !== 8'd0) begin n_err++; $display("FAIL reset_dropped_h: got %0d want 0", drop_h); end
    n_cmp++; if (tx_r !== 1'b1)   begin n_err++; $display("FAIL reset_tx_r: got %b want 1", tx_r); end
    n_cmp++; if (empty_r !== 1'b1) begin n_err++; $display("FAIL reset_empty_r: got %b want 1", empty_r); end
    n_cmp++; if (busy_r !== 1'b0) begin n_err++; $display("FAIL reset_busy_r: got %b want 0", busy_r); end
    $display("reset: tx=%b full=%b empty=%b busy=%b dropped=%0d", tx_h, full_h, empty_h, busy_h, drop_h);
  endtask

  task automatic test_hex_word();
    int unsigned n0; int bc; bit to;
    clear_queues();
    @(negedge clk); wr_h = 1'b1; din_h = 16'h1A2F; model_word(0, 16'h1A2F);
    @(negedge clk); wr_h = 1'b0; n0 = cyc;
    n_cmp++; if (empty_h !== 1'b0) begin n_err++; $display("FAIL hex_empty_N: got %b want 0", empty_h); end
    n_cmp++; if (busy_h !== 1'b0)  begin n_err++; $display("FAIL hex_busy_N: got %b want 0", busy_h); end
    @(negedge clk);
    n_cmp++; if (busy_h !== 1'b1)  begin n_err++; $display("FAIL hex_busy_N1: got %b want 1", busy_h); end
    n_cmp++; if (empty_h !== 1'b1) begin n_err++; $display("FAIL hex_empty_N1: got %b want 1", empty_h); end
    n_cmp++; if (tx_h !== 1'b1)    begin n_err++; $display("FAIL hex_tx_N1: got %b want 1", tx_h); end
    @(negedge clk);
    n_cmp++; if (tx_h !== 1'b0)    begin n_err++; $display("FAIL hex_tx_N2: got %b want 0", tx_h); end
    wait_idle(0, 3000, bc, to);
    bc = bc + 2;
    n_cmp++; if (to) begin n_err++; $display("FAIL hex_timeout: busy still %b want 0", busy_h); end
    // Busy rises one clock before the start bit and falls as the last stop bit ends.
    n_cmp++; if (bc < 960 || bc > 961) begin n_err++; $display("FAIL hex_busy_len: got %0d want 960..961", bc); end
    repeat (5) @(negedge clk);
    n_cmp++; if (rx_h.size() != 6) begin n_err++; $display("FAIL hex_nbytes: got %0d want 6", rx_h.size()); end
    for (int i = 0; i < exp_h.size() && i < rx_h.size(); i++) begin
      n_cmp++; if (rx_h[i] !== exp_h[i]) begin n_err++; $display("FAIL hex_byte%0d: got %02h want %02h", i, rx_h[i], exp_h[i]); end
    end
    for (int i = 1; i < ts_h.size(); i++) begin
      n_cmp++; if (ts_h[i] - ts_h[i-1] != 10 * BC) begin n_err++; $display("FAIL hex_contig%0d: got %0d want %0d", i, ts_h[i] - ts_h[i-1], 10 * BC); end
    end
    n_cmp++; if (ts_h.size() > 0 && ts_h[0] != n0 + 2) begin n_err++; $display("FAIL hex_start_edge: got %0d want %0d", ts_h[0], n0 + 2); end
    n_cmp++; if (ferr_h != 0) begin n_err++; $display("FAIL hex_frame_err: got %0d want 0", ferr_h); end
    $display("hex_word: 1A2F -> %0d chars, busy %0d clocks", rx_h.size(), bc);
  endtask

  task automatic test_raw_word();
    int bc; bit to;
    clear_queues();
    @(negedge clk); wr_r = 1'b1; din_r = 16'hBEEF; model_word(1, 16'hBEEF);
    @(negedge clk); wr_r = 1'b0;
    @(negedge clk);
    wait_idle(1, 2000, bc, to);
    bc = bc + 1;
    n_cmp++; if (to) begin n_err++; $display("FAIL raw_timeout: busy still %b want 0", busy_r); end
    n_cmp++; if (bc < 20 * BC || bc > 20 * BC + 1) begin n_err++; $display("FAIL raw_busy_len: got %0d want 320..321", bc); end
    repeat (40) @(negedge clk);
    n_cmp++; if (rx_r.size() != 2) begin n_err++; $display("FAIL raw_nbytes: got %0d want 2", rx_r.size()); end
    for (int i = 0; i < exp_r.size() && i < rx_r.size(); i++) begin
      n_cmp++; if (rx_r[i] !== exp_r[i]) begin n_err++; $display("FAIL raw_byte%0d: got %02h want %02h", i, rx_r[i], exp_r[i]); end
    end
    n_cmp++; if (ts_r.size() == 2 && ts_r[1] - ts_r[0] != 10 * BC) begin n_err++; $display("FAIL raw_contig: got %0d want 160", ts_r[1] - ts_r[0]); end
    n_cmp++; if (ferr_r != 0) begin n_err++; $display("FAIL raw_frame_err: got %0d want 0", ferr_r); end
    $display("raw_word: BEEF -> %0d bytes, busy %0d clocks", rx_r.size(), bc);
  endtask

  task automatic test_overflow();
    logic [15:0] w; int bc; bit to; int unsigned d;
    clear_queues();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 4) begin n_cmp++; if (full_h !== 1'b0) begin n_err++; $display("FAIL ovf_full_after4: got %b want 0", full_h); end end
      if (k == 5) begin n_cmp++; if (full_h !== 1'b1) begin n_err++; $display("FAIL ovf_full_after5: got %b want 1", full_h); end end
      w = 16'($urandom);
      wr_h = 1'b1; din_h = w;
      if (k < 5) model_word(0, w);
    end
    @(negedge clk); wr_h = 1'b0;
    n_cmp++; if (drop_h !== 8'd2) begin n_err++; $display("FAIL ovf_dropped: got %0d want 2", drop_h); end
    wait_idle(0, 6000, bc, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL ovf_timeout: busy still %b want 0", busy_h); end
    repeat (5) @(negedge clk);
    n_cmp++; if (empty_h !== 1'b1) begin n_err++; $display("FAIL ovf_empty_end: got %b want 1", empty_h); end
    n_cmp++; if (busy_h !== 1'b0)  begin n_err++; $display("FAIL ovf_busy_end: got %b want 0", busy_h); end
    n_cmp++; if (full_h !== 1'b0)  begin n_err++; $display("FAIL ovf_full_end: got %b want 0", full_h); end
    n_cmp++; if (rx_h.size() != 30) begin n_err++; $display("FAIL ovf_nbytes: got %0d want 30", rx_h.size()); end
    for (int i = 0; i < exp_h.size() && i < rx_h.size(); i++) begin
      n_cmp++; if (rx_h[i] !== exp_h[i]) begin n_err++; $display("FAIL ovf_byte%0d: got %02h want %02h", i, rx_h[i], exp_h[i]); end
    end
    for (int i = 1; i < ts_h.size(); i++) begin
      d = ts_h[i] - ts_h[i-1];
      n_cmp++;
      if ((i % 6 == 0) ? (d < 160 || d > 162) : (d != 160)) begin
        n_err++; $display("FAIL ovf_gap%0d: got %0d want %s", i, d, (i % 6 == 0) ? "160..162" : "160");
      end
    end
    n_cmp++; if (ferr_h != 0) begin n_err++; $display("FAIL ovf_frame_err: got %0d want 0", ferr_h); end
    $display("overflow: 7 writes, dropped=%0d, %0d chars out", drop_h, rx_h.size());
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge clk); wr_h = 1'b1; din_h = 16'($urandom);
    // Five writes land (one is popped on the second edge), every later one is dropped.
    repeat (100) @(negedge clk);
    n_cmp++; if (drop_h !== 8'd95) begin n_err++; $display("FAIL sat_dropped100: got %0d want 95", drop_h); end
    repeat (200) @(negedge clk);
    n_cmp++; if (drop_h !== 8'd255) begin n_err++; $display("FAIL sat_dropped300: got %0d want 255", drop_h); end
    repeat (50) @(negedge clk);
    n_cmp++; if (drop_h !== 8'd255) begin n_err++; $display("FAIL sat_dropped350: got %0d want 255", drop_h); end
    wr_h = 1'b0;
    $display("saturation: dropped=%0d after 350 held writes", drop_h);
    do_reset();
    n_cmp++; if (drop_h !== 8'd0) begin n_err++; $display("FAIL sat_dropped_reset: got %0d want 0", drop_h); end
  endtask

  task automatic test_reset_mid();
    int unsigned n0; int lows;
    clear_queues();
    @(negedge clk); wr_h = 1'b1; din_h = 16'h5A3C;
    @(negedge clk); din_h = 16'hC0DE; n0 = cyc;
    @(negedge clk); wr_h = 1'b0;
    for (int i = 0; i < 200 && cyc < n0 + 55; i++) @(negedge clk);
    n_cmp++; if (busy_h !== 1'b1)  begin n_err++; $display("FAIL rmid_busy_before: got %b want 1", busy_h); end
    n_cmp++; if (empty_h !== 1'b0) begin n_err++; $display("FAIL rmid_empty_before: got %b want 0", empty_h); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (tx_h !== 1'b1)    begin n_err++; $display("FAIL rmid_tx: got %b want 1", tx_h); end
    n_cmp++; if (busy_h !== 1'b0)  begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy_h); end
    n_cmp++; if (empty_h !== 1'b1) begin n_err++; $display("FAIL rmid_empty: got %b want 1", empty_h); end
    n_cmp++; if (full_h !== 1'b0)  begin n_err++; $display("FAIL rmid_full: got %b want 0", full_h); end
    n_cmp++; if (drop_h !== 8'd0)  begin n_err++; $display("FAIL rmid_dropped: got %0d want 0", drop_h); end
    reset = 1'b0;
    lows = 0;
    repeat (3000) begin @(negedge clk); if (tx_h !== 1'b1) lows++; end
    n_cmp++; if (lows != 0)        begin n_err++; $display("FAIL rmid_quiet: got %0d low clocks want 0", lows); end
    n_cmp++; if (rx_h.size() != 0) begin n_err++; $display("FAIL rmid_frames: got %0d want 0", rx_h.size()); end
    $display("reset_mid: tx=%b busy=%b, %0d frames after reset", tx_h, busy_h, rx_h.size());
  endtask

  task automatic test_streaming();
    logic [15:0] w; int bc; bit to; int unsigned d; int gap;
    clear_queues();
    for (int k = 0; k < 8; k++) begin
      w = 16'($urandom);
      model_word(1, w);
      @(negedge clk); wr_r = 1'b1; din_r = w;
      @(negedge clk); wr_r = 1'b0;
      gap = int'($urandom_range(0, 5));
      repeat (gap) @(negedge clk);
    end
    n_cmp++; if (busy_r !== 1'b1) begin n_err++; $display("FAIL stream_busy_mid: got %b want 1", busy_r); end
    wait_idle(1, 4000, bc, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL stream_timeout: busy still %b want 0", busy_r); end
    // Busy never dropped until every byte was on the line.
    n_cmp++; if (rx_r.size() != 16) begin n_err++; $display("FAIL stream_busy_cont: got %0d bytes at first idle want 16", rx_r.size()); end
    repeat (20) @(negedge clk);
    n_cmp++; if (drop_r !== 8'd0) begin n_err++; $display("FAIL stream_dropped: got %0d want 0", drop_r); end
    for (int i = 0; i < exp_r.size() && i < rx_r.size(); i++) begin
      n_cmp++; if (rx_r[i] !== exp_r[i]) begin n_err++; $display("FAIL stream_byte%0d: got %02h want %02h", i, rx_r[i], exp_r[i]); end
    end
    for (int i = 1; i < ts_r.size(); i++) begin
      d = ts_r[i] - ts_r[i-1];
      n_cmp++;
      if ((i % 2 == 0) ? (d < 160 || d > 162) : (d != 160)) begin
        n_err++; $display("FAIL stream_gap%0d: got %0d want %s", i, d, (i % 2 == 0) ? "160..162" : "160");
      end
    end
    n_cmp++; if (ferr_r != 0) begin n_err++; $display("FAIL stream_frame_err: got %0d want 0", ferr_r); end
    $display("streaming: 8 words -> %0d bytes", rx_r.size());
  endtask

  initial begin
    test_reset();
    test_hex_word();
    test_raw_word();
    test_overflow();
    test_saturation();
    test_reset_mid();
    test_streaming();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
